fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline. Holds the PC, drives the word address into the

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_stage_if_id_reg.sv | 44 ++++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset/NOP constants, word size, and the
// IF/ID bundle that the decode stage reuses.
package mips_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;  // sll $0,$0,0
  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // Clear the byte-offset bits so a PC can never become misaligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: the fetch stage drives a byte address and the
// combinational ROM returns the instruction word at that address.
interface fetch_stage_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (output imem_addr, input imem_instr);
  modport slave  (input imem_addr, output imem_instr);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load-enable hold, synchronous flush to a NOP
// bundle, synchronous active-high reset. Flush takes priority over load.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR_P = mips_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_en,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_q, q_d;
  if_id_t nop_bundle;

  assign nop_bundle = '{pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR_P, valid: 1'b0};

  // Next-state select: flush to NOP, load a new bundle, or hold.
  always_comb begin
    // NOTE: default assigned first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (flush) begin
      q_d = nop_bundle;
    end else if (load_en) begin
      q_d = d;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      q_q <= nop_bundle;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC mux
// (redirect > stall > advance) and the IF/ID register.
// Optional macro FETCH_STATS_EN adds fetch and stall counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  fetch_stage_if.master       imem,
  output logic [31:0]         if_id_pc,
  output logic [31:0]         if_id_pc_plus4,
  output logic [31:0]         if_id_instr,
  output logic                if_id_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         stat_fetch_cnt,
  output logic [31:0]         stat_stall_cnt
`endif
);

  import mips_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        stalled;
  if_id_t      if_id_in, if_id_out;

  assign pc_plus4 = pc_q + 32'(WORD_BYTES);
  assign advance  = !redirect_valid && !stall;
  assign stalled  = stall && !redirect_valid;

  // Next-PC mux: redirect target (aligned), hold on stall, else sequential.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  // PC register; reset value is aligned so pc[1:0] is always zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= align_word(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem.imem_addr = pc_q;

  assign if_id_in = '{pc: pc_q, pc_plus4: pc_plus4, instr: imem.imem_instr, valid: 1'b1};

  if_id_reg #(
    .NOP_INSTR_P (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_en (advance),
    .flush   (redirect_valid),
    .d       (if_id_in),
    .q       (if_id_out)
  );

  assign if_id_pc       = if_id_out.pc;
  assign if_id_pc_plus4 = if_id_out.pc_plus4;
  assign if_id_instr    = if_id_out.instr;
  assign if_id_valid    = if_id_out.valid;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'b0, advance};
    stall_cnt_d = stall_cnt_q + {31'b0, stalled};
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_fetch_cnt = fetch_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  // Without stats the stall qualifier has no consumer.
  logic unused_stalled;
  assign unused_stalled = stalled;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational ROM model.
// Stat-counter checks are compiled only when FETCH_STATS_EN is defined.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetch_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rom [64];

  fetch_stage_if ifc ();

  assign ifc.imem_instr = rom[ifc.imem_addr[7:2]];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (ifc),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One rising edge, then settle before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_0003;
    rom[2] = 32'h0109_5020;
    rom[3] = 32'hAC0A_0000;
    for (int i = 4; i < 64; i++) rom[i] = 32'hA000_0000 | 32'(i);

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_addr",  ifc.imem_addr, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc",    if_id_pc, 32'h0);

    // Free-running fetch
    step();
    check("f0_pc",    if_id_pc, 32'h0);
    check("f0_pc4",   if_id_pc_plus4, 32'h4);
    check("f0_instr", if_id_instr, 32'h2008_0005);
    check("f0_valid", {31'b0, if_id_valid}, 32'h1);
    check("f0_addr",  ifc.imem_addr, 32'h4);
    step();
    check("f1_pc",    if_id_pc, 32'h4);
    check("f1_instr", if_id_instr, 32'h2009_0003);
    check("f1_addr",  ifc.imem_addr, 32'h8);

    // Two stalled cycles at pc=0x8
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stl_addr",  ifc.imem_addr, 32'h8);
      check("stl_pc",    if_id_pc, 32'h4);
      check("stl_instr", if_id_instr, 32'h2009_0003);
    end
    stall = 1'b0;
    step();
    check("res_pc",    if_id_pc, 32'h8);
    check("res_instr", if_id_instr, 32'h0109_5020);
    check("res_addr",  ifc.imem_addr, 32'hC);

    // Redirect to unaligned target, alone and with a simultaneous stall
    for (int k = 0; k < 2; k++) begin
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0023; stall = (k == 1);
      step();
      redirect_valid = 1'b0; stall = 1'b0;
      check("rd_addr",  ifc.imem_addr, 32'h20);
      check("rd_valid", {31'b0, if_id_valid}, 32'h0);
      check("rd_instr", if_id_instr, 32'h0);
      step();
      check("rd_pc",    if_id_pc, 32'h20);
      check("rd_ins2",  if_id_instr, 32'hA000_0008);
      check("rd_val2",  {31'b0, if_id_valid}, 32'h1);
    end

    // PC wrap at 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wr_addr0", ifc.imem_addr, 32'hFFFF_FFFC);
    step();
    check("wr_addr1", ifc.imem_addr, 32'h0);
    check("wr_pc",    if_id_pc, 32'hFFFF_FFFC);
    check("wr_pc4",   if_id_pc_plus4, 32'h0);
    check("wr_instr", if_id_instr, 32'hA000_003F);

    // Mid-run reset at pc=0x14
    for (int i = 0; i < 5; i++) step();
    check("mr_pre",   ifc.imem_addr, 32'h14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_addr",  ifc.imem_addr, 32'h0);
    check("mr_valid", {31'b0, if_id_valid}, 32'h0);
    check("mr_instr", if_id_instr, 32'h0);

`ifdef FETCH_STATS_EN
    check("st_f0", stat_fetch_cnt, 32'h0);
    check("st_s0", stat_stall_cnt, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    // Stall with redirect counts neither a stall nor a fetch.
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("st_f5", stat_fetch_cnt, 32'd5);
    check("st_s3", stat_stall_cnt, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("st_fr", stat_fetch_cnt, 32'h0);
    check("st_sr", stat_stall_cnt, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
